// File: rtl/fft_params_pkg.sv
// fft_params: constants and FSM states shared by the FFT stage controller, RAM interface and butterfly.
package fft_params;
   localparam int FFT_N        = 32;
   localparam int FFT_BFLY_LAT = 3;
   localparam int LOG2N        = $clog2(FFT_N);
   localparam int STAGE_W      = $clog2(LOG2N) + 1;
   localparam int RD_LAT       = 1;
   typedef enum logic [2:0] {IDLE, READ, DRAIN, STAGE, DONE} state_e;
endpackage

// File: rtl/fft_wr_addr_pipe.sv
// fft_wr_addr_pipe: fixed-depth delay line carrying {valid, a1, a2} from read issue to write-back.
module fft_wr_addr_pipe #(
   parameter int DEPTH = 4,
   parameter int W     = 11
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] sr_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: radix-2 DIT stage sequencer; issues butterfly read pairs, twiddle indices
// and delayed write pairs against a ping-pong RAM, toggling banks between stages.
module fft_stage_ctrl
   import fft_params::*;
#(
   parameter  int N             = FFT_N,
   parameter  int BFLY_LAT      = FFT_BFLY_LAT,
   localparam int address_width = $clog2(N),
   localparam int SW            = $clog2($clog2(N)) + 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [SW-1:0]            stage_o,
   output logic                     bank_select_o,
   output logic                     read_en_o,
   output logic [address_width-1:0] rd_address1_o,
   output logic [address_width-1:0] rd_address2_o,
   output logic [address_width-2:0] tw_index_o,
   output logic                     wr_en_o,
   output logic [address_width-1:0] wr_address1_o,
   output logic [address_width-1:0] wr_address2_o
);
   localparam int STAGES = $clog2(N);
   localparam int DW     = $clog2(BFLY_LAT + 2);
   localparam int PW     = 1 + 2 * address_width;
   localparam logic [address_width-2:0] K_LAST = (address_width-1)'(N/2 - 1);
   localparam logic [DW-1:0]            D_LAST = DW'(BFLY_LAT);
   localparam logic [SW-1:0]            S_LAST = SW'(STAGES - 1);

   state_e                   state_q;
   logic [SW-1:0]            stage_q;
   logic [address_width-2:0] k_q;
   logic [DW-1:0]            dcnt_q;
   logic                     bank_q;
   logic [address_width-1:0] kx, half, pos, grp, a1, a2;
   logic [address_width-2:0] tw;
   logic [PW-1:0]            pipe_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         stage_q <= '0;
         k_q     <= '0;
         dcnt_q  <= '0;
         bank_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               state_q <= READ;
               stage_q <= '0;
               k_q     <= '0;
            end
            READ: begin
               k_q <= k_q + 1'b1;
               if (k_q == K_LAST) begin
                  state_q <= DRAIN;
                  dcnt_q  <= '0;
               end
            end
            // Covers the RAM read plus butterfly latency so the last write lands before the toggle.
            DRAIN: begin
               dcnt_q <= dcnt_q + 1'b1;
               if (dcnt_q == D_LAST) state_q <= STAGE;
            end
            STAGE: begin
               bank_q <= ~bank_q;
               if (stage_q == S_LAST) state_q <= DONE;
               else begin
                  stage_q <= stage_q + 1'b1;
                  state_q <= READ;
               end
            end
            DONE: begin
               state_q <= IDLE;
               stage_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      kx   = {1'b0, k_q};
      half = address_width'(1) << stage_q;
      pos  = kx & (half - 1'b1);
      grp  = kx >> stage_q;
      a1   = (grp << (stage_q + 1'b1)) | pos;
      a2   = a1 + half;
      tw   = (address_width-1)'(pos << (STAGES - 1 - int'(stage_q)));
   end

   assign busy_o        = state_q != IDLE;
   assign done_o        = state_q == DONE;
   assign read_en_o     = state_q == READ;
   assign stage_o       = stage_q;
   assign bank_select_o = bank_q;
   // Addresses are forced to zero when idle so invalid pipe entries also carry zeros.
   assign rd_address1_o = read_en_o ? a1 : '0;
   assign rd_address2_o = read_en_o ? a2 : '0;
   assign tw_index_o    = read_en_o ? tw : '0;

   fft_wr_addr_pipe #(.DEPTH(RD_LAT + BFLY_LAT), .W(PW)) u_pipe (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     ({read_en_o, rd_address1_o, rd_address2_o}),
      .q_o     (pipe_q)
   );

   assign {wr_en_o, wr_address1_o, wr_address2_o} = pipe_q;
endmodule
